// File: rtl/ic_bank_seq.sv
// Initial-condition bank and load sequencer for the chaotic oscillator.
// Stores NSETS (x0, y0, z0) triplets and presents one of them to the
// integrator over a valid/ready handshake: once automatically after reset,
// and then once per load request. In sweep mode successive loads walk
// through the sets in order.
module ic_bank_seq #(
    parameter int               WIDTH  = 16,
    parameter int               FRAC   = 13,
    parameter int               NSETS  = 4,
    parameter logic [WIDTH-1:0] X0_RST = 16'h0000,
    parameter logic [WIDTH-1:0] Y0_RST = 16'hE99A,
    parameter logic [WIDTH-1:0] Z0_RST = 16'h0000,
    localparam int              SETW   = $clog2(NSETS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [SETW-1:0]  wr_set_i,
    input  logic [1:0]       wr_var_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [SETW-1:0]  sel_i,
    input  logic             sweep_i,
    input  logic             load_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic             busy_o,
    output logic [SETW-1:0]  set_o,
    output logic [WIDTH-1:0] x0_o,
    output logic [WIDTH-1:0] y0_o,
    output logic [WIDTH-1:0] z0_o
);

    // FRAC only documents the fixed-point format; the data is copied raw.
    if (NSETS < 2 || (1 << SETW) != NSETS || FRAC >= WIDTH) begin : g_param_check
        $error("ic_bank_seq: NSETS must be a power of two >= 2 and FRAC < WIDTH");
    end

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        IDLE    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [SETW-1:0]   sweep_reg;
    logic [SETW-1:0]   load_idx;
    logic              capture;

    logic [WIDTH-1:0]  bank_x [NSETS];
    logic [WIDTH-1:0]  bank_y [NSETS];
    logic [WIDTH-1:0]  bank_z [NSETS];

    // The bank is held in flops (not RAM) because reset must restore it.
    for (genvar gi = 0; gi < NSETS; gi++) begin : g_set
        localparam logic [WIDTH-1:0] XR = (gi == 0) ? X0_RST : '0;
        localparam logic [WIDTH-1:0] YR = (gi == 0) ? Y0_RST : '0;
        localparam logic [WIDTH-1:0] ZR = (gi == 0) ? Z0_RST : '0;

        logic [WIDTH-1:0] x_reg;
        logic [WIDTH-1:0] y_reg;
        logic [WIDTH-1:0] z_reg;

        // Per-set storage: write the selected variable, var 3 is a no-op.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                x_reg <= XR;
                y_reg <= YR;
                z_reg <= ZR;
            end else if (wr_en_i && wr_set_i == SETW'(gi)) begin
                case (wr_var_i)
                    2'd0:    x_reg <= wr_data_i;
                    2'd1:    y_reg <= wr_data_i;
                    2'd2:    z_reg <= wr_data_i;
                    default: ;
                endcase
            end
        end

        assign bank_x[gi] = x_reg;
        assign bank_y[gi] = y_reg;
        assign bank_z[gi] = z_reg;
    end

    // Sequencer state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, load decision and status flags. valid/busy decode the
    // state directly so an asynchronous reset drops valid immediately.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        load_idx   = '0;
        valid_o    = 1'b0;
        busy_o     = 1'b1;
        case (state_reg)
            BOOT: begin
                capture    = 1'b1;
                load_idx   = '0;
                state_next = PRESENT;
            end
            IDLE: begin
                busy_o = 1'b0;
                if (load_i) begin
                    capture    = 1'b1;
                    load_idx   = sweep_i ? sweep_reg : sel_i;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // Sweep index advances on every completed handshake made in sweep mode;
    // NSETS is a power of two so the natural wrap is modulo NSETS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sweep_reg <= '0;
        end else if (state_reg == PRESENT && ready_i && sweep_i) begin
            sweep_reg <= sweep_reg + SETW'(1);
        end
    end

    // Output registers copy the bank at the load edge and then hold, so a
    // same-edge or later write never disturbs the presented triplet.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            set_o <= '0;
            x0_o  <= '0;
            y0_o  <= '0;
            z0_o  <= '0;
        end else if (capture) begin
            set_o <= load_idx;
            x0_o  <= bank_x[load_idx];
            y0_o  <= bank_y[load_idx];
            z0_o  <= bank_z[load_idx];
        end
    end

endmodule

// File: doc/ic_bank_seq.md
Name: ic_bank_seq

Overview:
- Parametrised initial-condition bank and load sequencer for the piece-wise-linear chaotic oscillator datapath.
- Holds NSETS writable triplets (x0, y0, z0) in signed fixed point.
- Presents one triplet to the integrator through a valid/ready handshake, automatically after reset and on request.
- Optionally steps through the sets on successive loads (sweep mode).

Parameters:
- WIDTH, 16: word width of every state variable, two's complement.
- FRAC, 13: fractional bits; documentation only, no arithmetic depends on it.
- NSETS, 4: number of stored triplets; power of two, at least 2. Localparam SETW = clog2(NSETS).
- X0_RST, 16'h0000: reset value of x0 in set 0 (0.0).
- Y0_RST, 16'hE99A: reset value of y0 in set 0 (-0.69995 in Q3.13).
- Z0_RST, 16'h0000: reset value of z0 in set 0 (0.0).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- wr_en_i  in  1  write strobe for the bank.
- wr_set_i  in  SETW  set index to write.
- wr_var_i  in  2  variable select: 0 = x, 1 = y, 2 = z, 3 = ignored (no write).
- wr_data_i  in  WIDTH  write data.
- sel_i  in  SETW  set index used by a non-sweep load.
- sweep_i  in  1  1 = each load uses an internal index that increments after every completed handshake.
- load_i  in  1  load request, sampled in IDLE only.
- ready_i  in  1  integrator accepts the triplet.
- valid_o  out  1  triplet on x0_o/y0_o/z0_o is valid.
- busy_o  out  1  sequencer is not in IDLE.
- set_o  out  SETW  index of the presented triplet.
- x0_o, y0_o, z0_o  out  WIDTH each  presented triplet, registered.

Behaviour:
- Reset (async assert, sync release):
  - Set 0 = (X0_RST, Y0_RST, Z0_RST); all other sets = 0.
  - Sweep index = 0; valid_o = 0; set_o = 0; outputs = 0.
  - busy_o = 1; state = BOOT.
- Bank write: on a clock edge with wr_en_i = 1 and wr_var_i != 3, update bank[wr_set_i][wr_var_i]. Writes are accepted in every state.
- FSM states:
  - BOOT: lasts one cycle, then behaves as a load of set 0 and goes to PRESENT. The boot load ignores sweep_i and sel_i.
  - IDLE: busy_o = 0, valid_o = 0. If load_i = 1, capture the index into set_o, capture the triplet into the output registers, and go to PRESENT. Index = sweep index if sweep_i = 1, else sel_i.
  - PRESENT: valid_o = 1, busy_o = 1.
    - Outputs and set_o hold stable until ready_i = 1 is sampled.
    - On ready_i = 1, go to IDLE with valid_o = 0 on the next cycle.
    - If sweep_i = 1 at the handshake, the sweep index increments modulo NSETS (NSETS-1 wraps to 0).
- Latency: load_i sampled in IDLE at edge n -> valid_o = 1 after edge n; with ready_i held high, valid_o is high for exactly one cycle.
- Capture rule: the triplet is copied at the load edge. A same-edge write to the selected set is not seen; the presented triplet keeps the old value. Writes during PRESENT do not change the outputs.
- load_i is ignored in BOOT and PRESENT (no queueing).
- ready_i is ignored outside PRESENT.
- After the handshake, x0_o/y0_o/z0_o and set_o keep their last values.
- Reset asserted mid-PRESENT: immediately valid_o = 0, the bank returns to reset contents, and the sequencer re-enters BOOT.
- No arithmetic: data is copied bit-exact, no saturation or sign handling.

Test Plan:
- Release reset, ready_i = 1 -> valid_o high for exactly one cycle after BOOT, set_o = 0, x0_o = 16'h0000, y0_o = 16'hE99A, z0_o = 16'h0000.
- Write set 2 = (16'h2000, 16'hE000, 16'h0800), sel_i = 2, pulse load_i, ready_i = 1 -> next cycle valid_o = 1, set_o = 2, outputs 1.0, -1.0, 0.25; IDLE one cycle later.
- ready_i low for 5 cycles during PRESENT while writing set 2 x = 16'h1234 -> outputs stay 16'h2000 and valid_o stays high until ready_i rises. A new load then presents 16'h1234.
- sweep_i = 1, NSETS = 4, six consecutive loads with immediate ready -> set_o sequence 0, 1, 2, 3, 0, 1.
- load_i on the same edge as a write of set 1 y = 16'h7FFF, sel_i = 1 -> presented y0_o = old value (0). A second load gives 16'h7FFF.
- Assert rst_i while valid_o = 1 with ready_i = 0 -> valid_o drops asynchronously. After release, written sets read back 0 and the boot load presents the reset values of set 0.
